// File: rtl/key_debounce_capture_if.sv
// ---------------------------------------------------------------------------
// key_debounce_capture_if
//   Groups the button-side and software-side signals of the key conditioner.
//   The DUT connects through the slave modport. The master modport is the view
//   of whoever drives the pins and the clear lines (board glue or a bench).
//
//   Signals (all NUM_KEYS wide, one bit per button channel)
//     key_n_in      raw pushbutton pins, 0 = pressed, asynchronous
//     capture_clr   level-sensitive clear for keys_capture
//     keys_level    debounced state, 1 = pressed
//     keys_press    one-cycle strobe on a debounced press
//     keys_release  one-cycle strobe on a debounced release
//     keys_capture  sticky press flag, cleared by capture_clr
// ---------------------------------------------------------------------------
interface key_debounce_capture_if #(
   parameter int NUM_KEYS = 4
);
   logic [NUM_KEYS-1:0] key_n_in;
   logic [NUM_KEYS-1:0] capture_clr;
   logic [NUM_KEYS-1:0] keys_level;
   logic [NUM_KEYS-1:0] keys_press;
   logic [NUM_KEYS-1:0] keys_release;
   logic [NUM_KEYS-1:0] keys_capture;

   modport master (
      output key_n_in,
      output capture_clr,
      input  keys_level,
      input  keys_press,
      input  keys_release,
      input  keys_capture
   );

   modport slave (
      input  key_n_in,
      input  capture_clr,
      output keys_level,
      output keys_press,
      output keys_release,
      output keys_capture
   );
endinterface

// File: rtl/key_debounce_capture.sv
// ---------------------------------------------------------------------------
// key_debounce_capture
//   Conditions the raw active-low board pushbuttons before they reach the
//   keys PIO. Every channel is independent: the pin is synchronised, contact
//   bounce is rejected by requiring DEBOUNCE_CYCLES consecutive identical
//   samples, and the channel produces a clean level, press/release strobes and
//   a sticky press-capture bit that software clears.
//
//   Ports
//     clk_clk      in   system clock, all logic on the rising edge
//     reset_reset  in   synchronous reset, active-low
//     bus          key_debounce_capture_if.slave (pins, clears, outputs)
//
//   Latency from a pin change (first registering edge = edge 1) to the level
//   change and strobe: SYNC_STAGES + DEBOUNCE_CYCLES edges. All outputs are
//   registered; there is no combinational path from input to output.
// ---------------------------------------------------------------------------
module key_debounce_capture #(
   parameter int NUM_KEYS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset,
   key_debounce_capture_if.slave        bus
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   // Count value at which the next agreeing sample completes the debounce.
   // The counter is loaded with 1 on leaving a stable state, so it never
   // needs to reach DEBOUNCE_CYCLES itself.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [NUM_KEYS-1:0] level_vec;
   logic [NUM_KEYS-1:0] press_vec;
   logic [NUM_KEYS-1:0] release_vec;
   logic [NUM_KEYS-1:0] capture_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
         logic [SYNC_STAGES-1:0] sync_reg;
         logic                   s;
         state_t                 state_reg, state_next;
         logic [CNT_W-1:0]       cnt_reg, cnt_next;
         logic                   level_reg, level_next;
         logic                   press_reg, press_next;
         logic                   release_reg, release_next;
         logic                   capture_reg, capture_next;

         // Synchroniser resets to 1 so a channel comes out of reset looking
         // released, even if the button is physically held.
         always_ff @(posedge clk_clk) begin
            if (!reset_reset) begin
               sync_reg <= '1;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.key_n_in[gi]};
            end
         end

         // Active-high "pressed" sample from the last synchroniser stage.
         assign s = ~sync_reg[SYNC_STAGES-1];

         always_ff @(posedge clk_clk) begin
            if (!reset_reset) begin
               state_reg   <= IDLE;
               cnt_reg     <= '0;
               level_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
               capture_reg <= 1'b0;
            end else begin
               state_reg   <= state_next;
               cnt_reg     <= cnt_next;
               level_reg   <= level_next;
               press_reg   <= press_next;
               release_reg <= release_next;
               capture_reg <= capture_next;
            end
         end

         always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            level_next   = level_reg;
            press_next   = 1'b0;
            release_next = 1'b0;

            unique case (state_reg)
               IDLE: begin
                  if (s) begin
                     if (DEBOUNCE_CYCLES == 1) begin
                        // A single sample is enough: accept immediately.
                        state_next = HELD;
                        cnt_next   = '0;
                        level_next = 1'b1;
                        press_next = 1'b1;
                     end else begin
                        state_next = PRESS_WAIT;
                        cnt_next   = CNT_ONE;
                     end
                  end
               end

               PRESS_WAIT: begin
                  if (!s) begin
                     // Bounce: drop back without any strobe.
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else if (cnt_reg == CNT_LAST) begin
                     state_next = HELD;
                     cnt_next   = '0;
                     level_next = 1'b1;
                     press_next = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + CNT_ONE;
                  end
               end

               HELD: begin
                  if (!s) begin
                     if (DEBOUNCE_CYCLES == 1) begin
                        state_next   = IDLE;
                        cnt_next     = '0;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                     end else begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = CNT_ONE;
                     end
                  end
               end

               RELEASE_WAIT: begin
                  if (s) begin
                     state_next = HELD;
                     cnt_next   = '0;
                  end else if (cnt_reg == CNT_LAST) begin
                     state_next   = IDLE;
                     cnt_next     = '0;
                     level_next   = 1'b0;
                     release_next = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + CNT_ONE;
                  end
               end

               default: begin
                  state_next = IDLE;
                  cnt_next   = '0;
                  level_next = 1'b0;
               end
            endcase
         end

         // Set has priority over clear so a press arriving while software is
         // clearing the flag is never lost.
         always_comb begin
            capture_next = capture_reg;
            if (press_reg) begin
               capture_next = 1'b1;
            end else if (bus.capture_clr[gi]) begin
               capture_next = 1'b0;
            end
         end

         assign level_vec[gi]   = level_reg;
         assign press_vec[gi]   = press_reg;
         assign release_vec[gi] = release_reg;
         assign capture_vec[gi] = capture_reg;
      end
   endgenerate

   assign bus.keys_level   = level_vec;
   assign bus.keys_press   = press_vec;
   assign bus.keys_release = release_vec;
   assign bus.keys_capture = capture_vec;

endmodule

// File: tb/tb_key_debounce_capture.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_capture
//   Directed bench for key_debounce_capture with SYNC_STAGES=2 and
//   DEBOUNCE_CYCLES=8 (latency 10 edges). Each cycle the four output vectors
//   are compared as one packed word {level, press, release, capture}.
// ---------------------------------------------------------------------------
module tb_key_debounce_capture;
   localparam int NK = 4;
   localparam int SS = 2;
   localparam int DC = 8;
   localparam int L  = SS + DC;

   logic clk_clk     = 1'b0;
   logic reset_reset = 1'b0;

   int errors = 0;
   int checks = 0;

   key_debounce_capture_if #(.NUM_KEYS(NK)) bus ();

   key_debounce_capture #(
      .NUM_KEYS        (NK),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .bus         (bus.slave)
   );

   always #5 clk_clk = ~clk_clk;

   // Observed word: hex digits are level, press, release, capture.
   logic [15:0] obs;
   assign obs = {bus.keys_level, bus.keys_press, bus.keys_release, bus.keys_capture};

   // Advance one rising edge and settle before sampling or driving.
   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic test_reset();
      bus.key_n_in    = 4'hF;
      bus.capture_clr = 4'h0;
      reset_reset     = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         step();
         checks++;
         if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold n=%0d got=%h want=%h", n, obs, 16'h0000);
         end
      end
      reset_reset = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         step();
         checks++;
         if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_idle n=%0d got=%h want=%h", n, obs, 16'h0000);
         end
      end
      $display("test_reset: 3 reset cycles, 15 idle cycles observed");
   endtask

   task automatic test_press();
      logic [3:0] lvl, prs, cap;
      bus.key_n_in = 4'hE;
      for (int n = 1; n <= 30; n++) begin
         step();
         lvl = (n >= L)     ? 4'b0001 : 4'b0000;
         prs = (n == L)     ? 4'b0001 : 4'b0000;
         cap = (n >= L + 1) ? 4'b0001 : 4'b0000;
         checks++;
         if (obs !== {lvl, prs, 4'h0, cap}) begin
            errors++;
            $display("FAIL press_ch0 n=%0d got=%h want=%h", n, obs, {lvl, prs, 4'h0, cap});
         end
      end
      $display("test_press: ch0 pressed for 30 cycles");
   endtask

   task automatic test_bounce();
      logic [3:0] lvl, prs, cap;
      bus.key_n_in = 4'hC;
      for (int n = 1; n <= 5; n++) begin
         step();
         checks++;
         if (obs !== 16'h1001) begin
            errors++;
            $display("FAIL bounce_low n=%0d got=%h want=%h", n, obs, 16'h1001);
         end
      end
      bus.key_n_in = 4'hE;
      for (int n = 1; n <= 2; n++) begin
         step();
         checks++;
         if (obs !== 16'h1001) begin
            errors++;
            $display("FAIL bounce_high n=%0d got=%h want=%h", n, obs, 16'h1001);
         end
      end
      bus.key_n_in = 4'hC;
      for (int n = 1; n <= 30; n++) begin
         step();
         lvl = (n >= L)     ? 4'b0011 : 4'b0001;
         prs = (n == L)     ? 4'b0010 : 4'b0000;
         cap = (n >= L + 1) ? 4'b0011 : 4'b0001;
         checks++;
         if (obs !== {lvl, prs, 4'h0, cap}) begin
            errors++;
            $display("FAIL bounce_final n=%0d got=%h want=%h", n, obs, {lvl, prs, 4'h0, cap});
         end
      end
      $display("test_bounce: ch1 low 5, high 2, low 30 cycles");
   endtask

   task automatic test_release_clear();
      logic [3:0] lvl, rel;
      bus.key_n_in = 4'hD;
      for (int n = 1; n <= 30; n++) begin
         step();
         lvl = (n >= L) ? 4'b0010 : 4'b0011;
         rel = (n == L) ? 4'b0001 : 4'b0000;
         checks++;
         if (obs !== {lvl, 4'h0, rel, 4'b0011}) begin
            errors++;
            $display("FAIL release_ch0 n=%0d got=%h want=%h", n, obs, {lvl, 4'h0, rel, 4'b0011});
         end
      end
      bus.capture_clr = 4'h1;
      step();
      checks++;
      if (obs !== 16'h2002) begin
         errors++;
         $display("FAIL clear_ch0 got=%h want=%h", obs, 16'h2002);
      end
      bus.capture_clr = 4'h0;
      step();
      checks++;
      if (obs !== 16'h2002) begin
         errors++;
         $display("FAIL clear_ch0_after got=%h want=%h", obs, 16'h2002);
      end
      $display("test_release_clear: ch0 released, capture cleared");
   endtask

   task automatic test_clear_collision();
      logic [3:0] lvl, prs, cap, rel;
      bus.key_n_in = 4'h9;
      for (int n = 1; n <= 12; n++) begin
         // Clear held across the cycle where the press strobe is high.
         if (n == 9) bus.capture_clr = 4'h4;
         step();
         lvl = (n >= L)     ? 4'b0110 : 4'b0010;
         prs = (n == L)     ? 4'b0100 : 4'b0000;
         cap = (n == L + 1) ? 4'b0110 : 4'b0010;
         checks++;
         if (obs !== {lvl, prs, 4'h0, cap}) begin
            errors++;
            $display("FAIL collide_ch2 n=%0d got=%h want=%h", n, obs, {lvl, prs, 4'h0, cap});
         end
      end
      bus.capture_clr = 4'h0;
      step();
      checks++;
      if (obs !== 16'h6002) begin
         errors++;
         $display("FAIL collide_after got=%h want=%h", obs, 16'h6002);
      end
      // Release everything and return to a quiet state.
      bus.key_n_in = 4'hF;
      for (int n = 1; n <= 15; n++) begin
         step();
         lvl = (n >= L) ? 4'b0000 : 4'b0110;
         rel = (n == L) ? 4'b0110 : 4'b0000;
         checks++;
         if (obs !== {lvl, 4'h0, rel, 4'b0010}) begin
            errors++;
            $display("FAIL quiesce n=%0d got=%h want=%h", n, obs, {lvl, 4'h0, rel, 4'b0010});
         end
      end
      bus.capture_clr = 4'hF;
      step();
      bus.capture_clr = 4'h0;
      checks++;
      if (obs !== 16'h0000) begin
         errors++;
         $display("FAIL quiesce_clear got=%h want=%h", obs, 16'h0000);
      end
      $display("test_clear_collision: ch2 press with concurrent clear");
   endtask

   task automatic test_reset_midcount();
      logic [3:0] lvl, prs, cap;
      bus.key_n_in = 4'h7;
      for (int n = 1; n <= 6; n++) begin
         step();
         checks++;
         if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL midcount_pre n=%0d got=%h want=%h", n, obs, 16'h0000);
         end
      end
      reset_reset = 1'b0;
      step();
      checks++;
      if (obs !== 16'h0000) begin
         errors++;
         $display("FAIL midcount_reset got=%h want=%h", obs, 16'h0000);
      end
      reset_reset = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         step();
         lvl = (n >= L)     ? 4'b1000 : 4'b0000;
         prs = (n == L)     ? 4'b1000 : 4'b0000;
         cap = (n >= L + 1) ? 4'b1000 : 4'b0000;
         checks++;
         if (obs !== {lvl, prs, 4'h0, cap}) begin
            errors++;
            $display("FAIL midcount_post n=%0d got=%h want=%h", n, obs, {lvl, prs, 4'h0, cap});
         end
      end
      $display("test_reset_midcount: ch3 held through reset");
   endtask

   initial begin
      bus.key_n_in    = 4'hF;
      bus.capture_clr = 4'h0;
      test_reset();
      test_press();
      test_bounce();
      test_release_clear();
      test_clear_collision();
      test_reset_midcount();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
